// File: rtl/rtc_alrm_sched.sv
// Multi-slot alarm scheduler sharing the single RTC ALRM comparator.
// Fires due slots on each tick, then reloads ALRM with the nearest deadline.
module rtc_alrm_sched #(
  parameter int ALRM_NUM  = 4,
  parameter int CNT_WIDTH = 32,
  parameter int IDX_WIDTH = $clog2(ALRM_NUM)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [1:0]           cfg_op_i,
  input  logic [IDX_WIDTH-1:0] cfg_idx_i,
  input  logic [CNT_WIDTH-1:0] cfg_time_i,
  input  logic [CNT_WIDTH-1:0] cfg_period_i,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic                 tick_i,
  output logic [CNT_WIDTH-1:0] alrm_o,
  output logic                 alrm_wr_o,
  output logic                 alrm_pend_o,
  output logic [ALRM_NUM-1:0]  fire_o,
  output logic                 ovr_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_SCAN,
    S_PROG
  } state_e;

  localparam int PW = IDX_WIDTH + 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(ALRM_NUM - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [ALRM_NUM-1:0] vld_q, vld_d;
  logic [ALRM_NUM-1:0] per_q, per_d;
  logic [CNT_WIDTH-1:0] tim_q [ALRM_NUM];
  logic [CNT_WIDTH-1:0] tim_d [ALRM_NUM];
  logic [CNT_WIDTH-1:0] prd_q [ALRM_NUM];
  logic [CNT_WIDTH-1:0] prd_d [ALRM_NUM];
  logic tick_pend_q, tick_pend_d;
  logic ovr_q, ovr_d;
  logic found_q, found_d;
  logic pend_q, pend_d;
  logic [CNT_WIDTH-1:0] best_q, best_d;
  logic [CNT_WIDTH-1:0] alrm_q, alrm_d;

  logic [IDX_WIDTH-1:0] sidx;
  logic signed [CNT_WIDTH-1:0] slot_dist;
  logic signed [CNT_WIDTH-1:0] best_dist;
  logic cfg_hs;
  logic idx_ok;
  logic op_set;
  logic op_can;
  logic last;
  logic slot_due;
  logic slot_better;
  logic wr_en;

  assign sidx   = ptr_q[IDX_WIDTH-1:0];
  assign last   = ptr_q == PTR_LAST;
  assign cfg_ready_o = state_q == S_IDLE;
  assign cfg_hs = cfg_valid_i && cfg_ready_o;
  assign idx_ok = {1'b0, cfg_idx_i} <= PTR_LAST;
  assign op_set = !cfg_op_i[1];
  assign op_can = cfg_op_i == 2'd2;

  // Distances are signed so deadlines just past a wrap still sort first.
  assign slot_dist = tim_q[sidx] - cnt_i;
  assign best_dist = best_q - cnt_i;
  assign slot_due  = vld_q[sidx] &&
                     (slot_dist[CNT_WIDTH-1] || slot_dist == '0);
  assign slot_better = vld_q[sidx] &&
                       (!found_q || slot_dist < best_dist);

  assign wr_en = (state_q == S_PROG) && found_q &&
                 (best_q != alrm_q || !pend_q);

  assign alrm_wr_o   = wr_en;
  assign alrm_o      = wr_en ? best_q : alrm_q;
  assign alrm_pend_o = (state_q == S_PROG) ? found_q : pend_q;
  assign ovr_o       = ovr_q;

  always_comb begin
    fire_o = '0;
    if (state_q == S_FIRE && slot_due) fire_o[sidx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    vld_d       = vld_q;
    per_d       = per_q;
    tim_d       = tim_q;
    prd_d       = prd_q;
    tick_pend_d = tick_pend_q;
    ovr_d       = ovr_q;
    found_d     = found_q;
    best_d      = best_q;
    alrm_d      = alrm_q;
    pend_d      = pend_q;

    if (tick_i && tick_pend_q) ovr_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_hs) begin
          if (idx_ok) begin
            unique case (1'b1)
              op_set: begin
                vld_d[cfg_idx_i] = 1'b1;
                per_d[cfg_idx_i] = cfg_op_i[0];
                tim_d[cfg_idx_i] = cfg_time_i;
                prd_d[cfg_idx_i] = cfg_period_i;
              end
              op_can: vld_d[cfg_idx_i] = 1'b0;
              default: ;
            endcase
          end
          if (tick_i) tick_pend_d = 1'b1;
          ptr_d   = '0;
          found_d = 1'b0;
          state_d = S_SCAN;
        end else if (tick_i || tick_pend_q) begin
          tick_pend_d = 1'b0;
          ptr_d       = '0;
          state_d     = S_FIRE;
        end
      end
      S_FIRE: begin
        if (tick_i) tick_pend_d = 1'b1;
        if (slot_due) begin
          if (per_q[sidx] && prd_q[sidx] != '0)
            tim_d[sidx] = tim_q[sidx] + prd_q[sidx];
          else
            vld_d[sidx] = 1'b0;
        end
        if (last) begin
          ptr_d   = '0;
          found_d = 1'b0;
          state_d = S_SCAN;
        end else begin
          ptr_d = ptr_q + PTR_ONE;
        end
      end
      S_SCAN: begin
        if (tick_i) tick_pend_d = 1'b1;
        if (slot_better) begin
          found_d = 1'b1;
          best_d  = tim_q[sidx];
        end
        if (last) state_d = S_PROG;
        else      ptr_d   = ptr_q + PTR_ONE;
      end
      S_PROG: begin
        if (tick_i) tick_pend_d = 1'b1;
        if (wr_en) alrm_d = best_q;
        pend_d  = found_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      vld_q       <= '0;
      per_q       <= '0;
      tick_pend_q <= 1'b0;
      ovr_q       <= 1'b0;
      found_q     <= 1'b0;
      pend_q      <= 1'b0;
      best_q      <= '0;
      alrm_q      <= '0;
      for (int i = 0; i < ALRM_NUM; i++) begin
        tim_q[i] <= '0;
        prd_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      vld_q       <= vld_d;
      per_q       <= per_d;
      tick_pend_q <= tick_pend_d;
      ovr_q       <= ovr_d;
      found_q     <= found_d;
      pend_q      <= pend_d;
      best_q      <= best_d;
      alrm_q      <= alrm_d;
      for (int i = 0; i < ALRM_NUM; i++) begin
        tim_q[i] <= tim_d[i];
        prd_q[i] <= prd_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rtc_alrm_sched.sv
// Bench for rtc_alrm_sched: directed scenarios plus random cfg/tick traffic
// compared against a slot-level behavioural model.
module tb_rtc_alrm_sched;

  localparam int N = 4;
  localparam int W = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [1:0] cfg_op = '0;
  logic [IW-1:0] cfg_idx = '0;
  logic [W-1:0] cfg_time = '0;
  logic [W-1:0] cfg_period = '0;
  logic [W-1:0] cnt_i = '0;
  logic tick_i = 1'b0;
  logic [W-1:0] alrm_o;
  logic alrm_wr_o;
  logic alrm_pend_o;
  logic [N-1:0] fire_o;
  logic ovr_o;

  int n_chk = 0;
  int n_err = 0;

  logic         m_vld [N];
  logic         m_per [N];
  logic [W-1:0] m_tim [N];
  logic [W-1:0] m_prd [N];
  logic         m_pend = 1'b0;
  logic [W-1:0] m_alrm = '0;
  logic         m_ovr = 1'b0;

  rtc_alrm_sched #(.ALRM_NUM(N), .CNT_WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_op_i    (cfg_op),
    .cfg_idx_i   (cfg_idx),
    .cfg_time_i  (cfg_time),
    .cfg_period_i(cfg_period),
    .cnt_i       (cnt_i),
    .tick_i      (tick_i),
    .alrm_o      (alrm_o),
    .alrm_wr_o   (alrm_wr_o),
    .alrm_pend_o (alrm_pend_o),
    .fire_o      (fire_o),
    .ovr_o       (ovr_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_scan(output logic f, output logic [W-1:0] b);
    int bd;
    f = 1'b0;
    b = '0;
    bd = 0;
    for (int i = 0; i < N; i++) begin
      if (m_vld[i] && (!f || int'(m_tim[i] - cnt_i) < bd)) begin
        f = 1'b1;
        b = m_tim[i];
        bd = int'(m_tim[i] - cnt_i);
      end
    end
  endtask

  task automatic model_tick(input logic [W-1:0] c, output logic [N-1:0] fm);
    fm = '0;
    for (int i = 0; i < N; i++) begin
      if (m_vld[i] && int'(m_tim[i] - c) <= 0) begin
        fm[i] = 1'b1;
        if (m_per[i] && m_prd[i] != 0) m_tim[i] = m_tim[i] + m_prd[i];
        else m_vld[i] = 1'b0;
      end
    end
  endtask

  task automatic fire_phase(input logic [N-1:0] fm, input bit extra);
    logic [N-1:0] one;
    one = 1;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk("fire", fire_o, fm & (one << k));
      chk("fire_rdy", cfg_ready, 0);
      if (extra && k == 1) tick_i = 1'b1;
      if (extra && k == 2) tick_i = 1'b0;
    end
  endtask

  task automatic scan_prog(input bit extra);
    logic f;
    logic [W-1:0] b;
    logic wr;
    model_scan(f, b);
    wr = f && (b != m_alrm || !m_pend);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk("scan_wr", alrm_wr_o, 0);
      chk("scan_fire", fire_o, 0);
      if (extra && k == 0) tick_i = 1'b1;
      if (extra && k == 1) tick_i = 1'b0;
    end
    @(negedge clk);
    chk("prog_wr", alrm_wr_o, wr);
    chk("prog_alrm", alrm_o, wr ? b : m_alrm);
    chk("prog_pend", alrm_pend_o, f);
    if (wr) m_alrm = b;
    m_pend = f;
    @(negedge clk);
    chk("idle_rdy", cfg_ready, 1);
    chk("idle_wr", alrm_wr_o, 0);
    chk("idle_alrm", alrm_o, m_alrm);
    chk("idle_pend", alrm_pend_o, m_pend);
    chk("ovr", ovr_o, m_ovr);
  endtask

  task automatic do_cfg(input logic [1:0] op, input logic [IW-1:0] idx,
                        input logic [W-1:0] t, input logic [W-1:0] p,
                        input logic [W-1:0] c);
    @(posedge clk);
    #1;
    chk("cfg_rdy", cfg_ready, 1);
    cnt_i = c;
    cfg_valid = 1'b1;
    cfg_op = op;
    cfg_idx = idx;
    cfg_time = t;
    cfg_period = p;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    if (op <= 2'd1) begin
      m_vld[idx] = 1'b1;
      m_per[idx] = op[0];
      m_tim[idx] = t;
      m_prd[idx] = p;
    end else if (op == 2'd2) begin
      m_vld[idx] = 1'b0;
    end
    scan_prog(0);
  endtask

  task automatic do_tick(input logic [W-1:0] c, input bit extra);
    logic [N-1:0] fm;
    @(posedge clk);
    #1;
    cnt_i = c;
    tick_i = 1'b1;
    @(posedge clk);
    #1;
    tick_i = 1'b0;
    model_tick(c, fm);
    fire_phase(fm, extra);
    if (extra) m_ovr = 1'b1;
    scan_prog(extra);
    if (extra) begin
      model_tick(c, fm);
      fire_phase(fm, 0);
      scan_prog(0);
    end
  endtask

  initial begin
    logic [W-1:0] t;
    logic [W-1:0] p;
    int r;
    for (int i = 0; i < N; i++) begin
      m_vld[i] = 1'b0;
      m_per[i] = 1'b0;
      m_tim[i] = '0;
      m_prd[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_rdy", cfg_ready, 1);
    chk("rst_alrm", alrm_o, 0);
    chk("rst_wr", alrm_wr_o, 0);
    chk("rst_pend", alrm_pend_o, 0);
    chk("rst_fire", fire_o, 0);
    chk("rst_ovr", ovr_o, 0);
    rst_n = 1'b1;

    do_cfg(2'd0, 2'd2, 32'd100, 32'd0, 32'd90);
    chk("t2_alrm", alrm_o, 32'd100);
    do_tick(32'd100, 0);
    chk("t2_pend", alrm_pend_o, 0);

    do_cfg(2'd1, 2'd0, 32'd10, 32'd5, 32'd8);
    do_cfg(2'd0, 2'd1, 32'd12, 32'd0, 32'd8);
    do_tick(32'd10, 0);
    chk("t3_alrm_a", alrm_o, 32'd12);
    do_tick(32'd12, 0);
    chk("t3_alrm_b", alrm_o, 32'd15);

    do_cfg(2'd2, 2'd0, 32'd0, 32'd0, 32'hFFFF_FFF0);
    do_cfg(2'd1, 2'd3, 32'hFFFF_FFFE, 32'd4, 32'hFFFF_FFF0);
    do_tick(32'hFFFF_FFFE, 0);
    chk("t4_wrap", alrm_o, 32'h2);
    do_cfg(2'd0, 2'd0, 32'h1, 32'd0, 32'hFFFF_FFFE);
    chk("t4_signed", alrm_o, 32'h1);

    do_cfg(2'd2, 2'd0, 32'd0, 32'd0, 32'd40);
    do_cfg(2'd2, 2'd3, 32'd0, 32'd0, 32'd40);
    do_cfg(2'd0, 2'd0, 32'd50, 32'd0, 32'd40);
    do_cfg(2'd0, 2'd1, 32'd50, 32'd0, 32'd40);
    do_cfg(2'd2, 2'd0, 32'd0, 32'd0, 32'd40);
    chk("t5_alrm", alrm_o, 32'd50);

    do_cfg(2'd2, 2'd1, 32'd0, 32'd0, 32'd5);
    do_cfg(2'd0, 2'd0, 32'd20, 32'd0, 32'd5);
    do_tick(32'd5, 1);
    chk("t6_ovr", ovr_o, 1);

    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 4);
      if (r < 3) begin
        t = cnt_i + 32'($urandom_range(0, 60)) - 32'd20;
        p = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 30));
        do_cfg(2'($urandom_range(0, 3)), IW'($urandom_range(0, N - 1)),
               t, p, cnt_i);
      end else begin
        do_tick(cnt_i + 32'($urandom_range(0, 25)), 0);
      end
    end

    do_cfg(2'd0, 2'd0, cnt_i, 32'd0, cnt_i);
    @(posedge clk);
    #1;
    tick_i = 1'b1;
    @(posedge clk);
    #1;
    tick_i = 1'b0;
    @(negedge clk);
    chk("mid_fire", fire_o[0], 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", cfg_ready, 1);
    chk("mid_rst_fire", fire_o, 0);
    chk("mid_rst_pend", alrm_pend_o, 0);
    chk("mid_rst_ovr", ovr_o, 0);
    chk("mid_rst_alrm", alrm_o, 0);
    chk("mid_rst_wr", alrm_wr_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
